lsu_mem_port: RTL
=================

# lsu_mem_port

Load/store initiator that sits between the core's execute stage and the word-addressed data memory. It accepts one byte-addressed load or store request at a time through a valid/ready handshake. It drives the memory's word-address, write-enable and write-data inputs, and performs little-endian byte/halfword extraction with sign or zero extension on loads. Sub-word stores are done as a read-modify-write, because the memory only supports whole-word writes.

## Interface
- DATA_WIDTH, 32, memory word width; fixed at 32 for RV32 byte-lane logic
- ADDR_WIDTH, 8, memory word-address width; request byte address is ADDR_WIDTH+2 bits
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when high (ignored for word loads and stores)
- req_addr  in  ADDR_WIDTH+2  byte address
- req_wdata  in  DATA_WIDTH  store data; sub-word stores use the low bits
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  load result, valid with rsp_valid; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal-size request, valid with rsp_valid
- mem_we  out  1  memory write enable
- mem_a  out  ADDR_WIDTH  memory word address = latched req_addr[ADDR_WIDTH+1:2]
- mem_wd  out  DATA_WIDTH  memory write data
- mem_rd  in  DATA_WIDTH  memory read data, combinational from mem_a

## Operation
- **States:** IDLE, ACCESS, WRITE, RESP.
- **IDLE:**
  - req_ready=1.
  - On req_valid, latch we/size/unsigned/addr/wdata.
  - Misaligned requests go to RESP with error set. Misaligned means: half with addr[0]=1, word with addr[1:0]≠0, or size=11. No memory access is made.
  - Otherwise go to ACCESS.
- **ACCESS:** mem_a = latched word address.
  - Load: select the byte lane(s) of mem_rd by addr[1:0] and extend. Signed byte uses bit 7, signed half uses bit 15. Register the result into rsp_rdata, then go to RESP.
  - Word store: mem_we=1, mem_wd=latched wdata, then go to RESP.
  - Byte/half store: register a merge of mem_rd with wdata[7:0] or wdata[15:0] at lane addr[1:0], other lanes unchanged, then go to WRITE.
- **WRITE:** mem_we=1, mem_wd=merged word, mem_a held; then go to RESP.
- **RESP:** rsp_valid=1 for exactly one cycle, rsp_err and rsp_rdata stable; then go to IDLE. Responses have no backpressure.
- **mem_we:** decoded from state; high only in ACCESS (word store) or WRITE, and never more than once per request.
- **mem_a, mem_wd outside write cycles:** hold last latched values; memory ignores them while mem_we=0.
- **Requests while busy:** req_valid while not in IDLE is ignored (req_ready=0); the requester holds the request.

## Timing
- **Reset values (asynchronous):**
  - state=IDLE
  - req_ready=1
  - rsp_valid=0, rsp_err=0, rsp_rdata=0
  - mem_we=0, mem_a=0, mem_wd=0
  - all latches 0
- **Latency,** with accept at edge T:
  - Load: rsp_valid in cycle T+2.
  - Word store: write at T+1, rsp_valid at T+2.
  - Sub-word store: read at T+1, write at T+2, rsp_valid at T+3.
  - Error: rsp_valid at T+1.
- **Throughput:** next accept is possible the cycle after RESP, so a load takes 3 cycles and a sub-word store 4 cycles.
- **Reset mid-operation:** state returns to IDLE immediately and mem_we drops without waiting for a clock edge. An interrupted RMW leaves the memory word unmodified. No rsp_valid is produced for the aborted request.
- **Wrap-around:** word address is the top ADDR_WIDTH bits of req_addr; no carry or wrap logic, and the highest word (255) is reachable.

## Test plan
- **Word store then load:** store word 0xDEADBEEF at byte addr 0x010, then load word 0x010 → mem_we high once on word 4; load rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid at T+2.
- **Byte RMW:** word 1 holds 0x11223344; store byte 0xAB at addr 0x005 → mem_we high only at T+2 with mem_wd=0x1122AB44; rsp_valid at T+3.
- **Sign/zero extension:** signed byte load at 0x005 → 0xFFFFFFAB; unsigned byte load → 0x000000AB; signed half load at 0x006 of 0x8001xxxx → 0xFFFF8001.
- **Misaligned:** load word at 0x006, store half at 0x003, size=11 → each gives rsp_valid at T+1 with rsp_err=1 and rsp_rdata=0; mem_we stays 0 throughout.
- **Held requests:** req_valid held high across two requests → req_ready low for all non-IDLE cycles; second request accepted only after RESP; exactly one rsp_valid per request.
- **Reset during WRITE:** assert rst in WRITE → mem_we low immediately; after release, load of the same word returns the original value; no rsp_valid for the aborted request.

Source files
------------

// File: rtl/lsu_mem_port_if.sv
// Request/response and data-memory bundles for lsu_mem_port.
// lsu_req_if: core <-> LSU handshake; lsu_dmem_if: LSU <-> word memory.
interface lsu_req_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [1:0]              req_size;
  logic                    req_unsigned;
  logic [ADDR_WIDTH+1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

interface lsu_dmem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem_rd;

  modport master (
    output mem_we, mem_a, mem_wd,
    input  mem_rd
  );

  modport slave (
    input  mem_we, mem_a, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store port: byte-addressed requests onto a word memory.
// Ports: clk, rst, req (lsu_req_if.slave), mem (lsu_dmem_if.master).
module lsu_mem_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  lsu_req_if.slave   req,
  lsu_dmem_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_t;

  state_t      state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic                  bad;
  logic [7:0]            rd_b;
  logic [15:0]           rd_h;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [4:0]            sh;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] ins;
  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    bad = (req.req_size == 2'b11) ||
          (req.req_size == 2'b01 && req.req_addr[0]) ||
          (req.req_size == 2'b10 && |req.req_addr[1:0]);
  end

  always_comb begin
    rd_b = mem.mem_rd[7:0];
    unique case (lane_q)
      2'd0: rd_b = mem.mem_rd[7:0];
      2'd1: rd_b = mem.mem_rd[15:8];
      2'd2: rd_b = mem.mem_rd[23:16];
      2'd3: rd_b = mem.mem_rd[31:24];
    endcase
    rd_h = lane_q[1] ? mem.mem_rd[31:16]
                     : mem.mem_rd[15:0];
    ld_data = mem.mem_rd;
    unique case (1'b1)
      (size_q == 2'b00):
        ld_data = {{(DATA_WIDTH-8){~uns_q & rd_b[7]}},
                   rd_b};
      (size_q == 2'b01):
        ld_data = {{(DATA_WIDTH-16){~uns_q & rd_h[15]}},
                   rd_h};
      default: ld_data = mem.mem_rd;
    endcase
  end

  // Sub-word store: replace only the addressed lane(s).
  always_comb begin
    sh   = {lane_q, 3'b000};
    mask = size_q[0] ? {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF}
                     : {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
    mask = mask << sh;
    ins  = {{(DATA_WIDTH-16){1'b0}},
            size_q[0] ? wdata_q : {8'h00, wdata_q[7:0]}};
    ins  = ins << sh;
    merged = (mem.mem_rd & ~mask) | ins;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      lane_q        <= 2'b00;
      wdata_q       <= '0;
      req.req_ready <= 1'b1;
      req.rsp_valid <= 1'b0;
      req.rsp_err   <= 1'b0;
      req.rsp_rdata <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_a     <= '0;
      mem.mem_wd    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req.req_valid) begin
            we_q          <= req.req_we;
            size_q        <= req.req_size;
            uns_q         <= req.req_unsigned;
            lane_q        <= req.req_addr[1:0];
            wdata_q       <= req.req_wdata[15:0];
            mem.mem_a     <= req.req_addr[ADDR_WIDTH+1:2];
            req.req_ready <= 1'b0;
            req.rsp_rdata <= '0;
            req.rsp_err   <= 1'b0;
            if (bad) begin
              state         <= RESP;
              req.rsp_valid <= 1'b1;
              req.rsp_err   <= 1'b1;
            end else begin
              state <= ACCESS;
              if (req.req_we && req.req_size == 2'b10) begin
                mem.mem_we <= 1'b1;
                mem.mem_wd <= req.req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            req.rsp_rdata <= ld_data;
            req.rsp_valid <= 1'b1;
            state         <= RESP;
          end else if (size_q == 2'b10) begin
            mem.mem_we    <= 1'b0;
            req.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            mem.mem_wd <= merged;
            mem.mem_we <= 1'b1;
            state      <= WRITE;
          end
        end
        WRITE: begin
          mem.mem_we    <= 1'b0;
          req.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          req.rsp_valid <= 1'b0;
          req.req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
